// File: rtl/msdap_pkg.sv
// msdap_pkg: shared definitions for the MSDAP input stage and control FSM.
//   WORD_W   - bits per serial audio word
//   ZERO_RUN - consecutive all-zero word pairs that signal sleep
//   s2p_state_e - serial-to-parallel FSM states
package msdap_pkg;

  localparam int unsigned WORD_W   = 16;
  localparam int unsigned ZERO_RUN = 800;

  typedef enum logic {
    IDLE,
    SHIFT
  } s2p_state_e;

endpackage

// File: rtl/zero_run_detector.sv
// zero_run_detector: counts consecutive word pairs that carried no 1 bit and
// raises all_zeros once the run reaches ZERO_RUN.
//   clk       - system clock, rising edge
//   clear     - synchronous clear (reset or control clear), highest priority
//   bit_one   - a 1 was sampled on either serial input this cycle
//   word_done - the current word pair completes this cycle
//   all_zeros - registered, high while the run count equals ZERO_RUN
module zero_run_detector #(
  parameter int unsigned ZERO_RUN = msdap_pkg::ZERO_RUN
) (
  input  logic clk,
  input  logic clear,
  input  logic bit_one,
  input  logic word_done,
  output logic all_zeros
);

  localparam int unsigned CNT_W = $clog2(ZERO_RUN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ZERO_RUN);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             seen_q, seen_d;
  logic             az_q, az_d;

  // seen_q remembers a 1 from earlier in the current word, so a pair whose
  // ones were all before the LSB is still not counted as a zero pair.
  always_comb begin
    cnt_d  = cnt_q;
    seen_d = seen_q;
    az_d   = az_q;
    if (clear) begin
      cnt_d  = '0;
      seen_d = 1'b0;
      az_d   = 1'b0;
    end else begin
      if (bit_one) begin
        cnt_d = '0;
      end else if (word_done && !seen_q && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end
      seen_d = word_done ? 1'b0 : (seen_q | bit_one);
      az_d   = (cnt_d == CNT_MAX);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q  <= cnt_d;
    seen_q <= seen_d;
    az_q   <= az_d;
  end

  assign all_zeros = az_q;

endmodule

// File: rtl/msdap_s2p.sv
// msdap_s2p: deserialises the left/right MSB-first serial streams into
// WORD_W-bit words and flags long all-zero runs for the sleep decision.
//   clk       - system clock, rising edge
//   reset_n   - synchronous active-low reset
//   s2p_clear - synchronous clear from control, same effect as reset
//   in_ready  - control allows a capture; only looked at when frame starts a word
//   frame     - high on the cycle carrying the MSB
//   in_l/in_r - serial data bits
//   data_l/data_r - last completed words
//   s2p_done  - one-cycle pulse when data_l/data_r update
//   all_zeros - high while the zero run has reached ZERO_RUN
module msdap_s2p #(
  parameter int unsigned WORD_W   = msdap_pkg::WORD_W,
  parameter int unsigned ZERO_RUN = msdap_pkg::ZERO_RUN
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s2p_clear,
  input  logic              in_ready,
  input  logic              frame,
  input  logic              in_l,
  input  logic              in_r,
  output logic [WORD_W-1:0] data_l,
  output logic [WORD_W-1:0] data_r,
  output logic              s2p_done,
  output logic              all_zeros
);

  import msdap_pkg::*;

  localparam int unsigned BC_W = $clog2(WORD_W);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 1);
  localparam logic [BC_W-1:0] FIRST_CNT = BC_W'(1);

  s2p_state_e        state_q, state_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] shift_l_q, shift_l_d;
  logic [WORD_W-1:0] shift_r_q, shift_r_d;
  logic [WORD_W-1:0] data_l_q, data_l_d;
  logic [WORD_W-1:0] data_r_q, data_r_d;
  logic              done_q, done_d;

  logic clear;
  logic bit_one;
  logic word_done;

  assign clear = !reset_n || s2p_clear;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_l_d = shift_l_q;
    shift_r_d = shift_r_q;
    data_l_d  = data_l_q;
    data_r_d  = data_r_q;
    done_d    = 1'b0;
    bit_one   = 1'b0;
    word_done = 1'b0;

    if (clear) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      shift_l_d = '0;
      shift_r_d = '0;
      data_l_d  = '0;
      data_r_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame && in_ready) begin
            shift_l_d = {{(WORD_W-1){1'b0}}, in_l};
            shift_r_d = {{(WORD_W-1){1'b0}}, in_r};
            bit_cnt_d = FIRST_CNT;
            bit_one   = in_l | in_r;
            state_d   = SHIFT;
          end
        end
        SHIFT: begin
          bit_one = in_l | in_r;
          if (frame) begin
            // Resync: drop the partial word and restart on this MSB.
            shift_l_d = {{(WORD_W-1){1'b0}}, in_l};
            shift_r_d = {{(WORD_W-1){1'b0}}, in_r};
            bit_cnt_d = FIRST_CNT;
          end else begin
            shift_l_d = {shift_l_q[WORD_W-2:0], in_l};
            shift_r_d = {shift_r_q[WORD_W-2:0], in_r};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
              data_l_d  = shift_l_d;
              data_r_d  = shift_r_d;
              done_d    = 1'b1;
              word_done = 1'b1;
              bit_cnt_d = '0;
              state_d   = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    bit_cnt_q <= bit_cnt_d;
    shift_l_q <= shift_l_d;
    shift_r_q <= shift_r_d;
    data_l_q  <= data_l_d;
    data_r_q  <= data_r_d;
    done_q    <= done_d;
  end

  zero_run_detector #(
    .ZERO_RUN(ZERO_RUN)
  ) u_zero_run (
    .clk      (clk),
    .clear    (clear),
    .bit_one  (bit_one),
    .word_done(word_done),
    .all_zeros(all_zeros)
  );

  assign data_l   = data_l_q;
  assign data_r   = data_r_q;
  assign s2p_done = done_q;

endmodule

// File: tb/tb_msdap_s2p.sv
// tb_msdap_s2p: directed checks of the serial-to-parallel input stage.
module tb_msdap_s2p;

  logic        clk;
  logic        reset_n;
  logic        s2p_clear;
  logic        in_ready;
  logic        frame;
  logic        in_l;
  logic        in_r;
  logic [15:0] data_l;
  logic [15:0] data_r;
  logic        s2p_done;
  logic        all_zeros;

  int unsigned passed;
  int unsigned total;

  msdap_s2p #(
    .WORD_W  (16),
    .ZERO_RUN(800)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .s2p_clear(s2p_clear),
    .in_ready (in_ready),
    .frame    (frame),
    .in_l     (in_l),
    .in_r     (in_r),
    .data_l   (data_l),
    .data_r   (data_r),
    .s2p_done (s2p_done),
    .all_zeros(all_zeros)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one serial cycle on the falling edge; return just after the rising edge.
  task automatic step(input logic f, input logic l, input logic r);
    @(negedge clk);
    frame = f;
    in_l  = l;
    in_r  = r;
    @(posedge clk);
    #1;
  endtask

  // One framed word, MSB first; counts s2p_done pulses seen before the LSB edge.
  task automatic send_word(input logic [15:0] l, input logic [15:0] r, output int unsigned early);
    early = 0;
    for (int i = 0; i < 16; i++) begin
      step(i == 0, l[15-i], r[15-i]);
      if (i < 15 && s2p_done) early++;
    end
  endtask

  task automatic zero_words(input int unsigned n, output int unsigned az_seen,
                            output int unsigned dones);
    int unsigned e;
    az_seen = 0;
    dones   = 0;
    for (int unsigned k = 0; k < n; k++) begin
      send_word(16'h0000, 16'h0000, e);
      if (all_zeros) az_seen++;
      if (s2p_done) dones++;
    end
  endtask

  logic [15:0] b2b_l [3];
  logic [15:0] b2b_r [3];
  logic [15:0] w;
  int unsigned early;
  int unsigned d;
  int unsigned az_seen;
  int unsigned dones;

  initial begin
    passed = 0;
    total  = 0;
    b2b_l = '{16'h0001, 16'h8000, 16'hFFFF};
    b2b_r = '{16'h7FFE, 16'h0000, 16'hC001};
    reset_n = 1'b0; s2p_clear = 1'b0; in_ready = 1'b0;
    frame = 1'b0; in_l = 1'b0; in_r = 1'b0;

    // Reset values
    repeat (3) step(1'b0, 1'b0, 1'b0);
    check("rst_data_l", 32'(data_l), 32'h0);
    check("rst_data_r", 32'(data_r), 32'h0);
    check("rst_done", 32'(s2p_done), 32'h0);
    check("rst_all_zeros", 32'(all_zeros), 32'h0);
    reset_n = 1'b1;
    in_ready = 1'b1;
    step(1'b0, 1'b0, 1'b0);

    // Single word
    send_word(16'hA5C3, 16'h1234, early);
    check("single_early", early, 32'h0);
    check("single_done", 32'(s2p_done), 32'h1);
    check("single_data_l", 32'(data_l), 32'hA5C3);
    check("single_data_r", 32'(data_r), 32'h1234);
    step(1'b0, 1'b0, 1'b0);
    check("single_done_fall", 32'(s2p_done), 32'h0);
    check("single_hold_l", 32'(data_l), 32'hA5C3);

    // Back-to-back at a 16-cycle period
    for (int k = 0; k < 3; k++) begin
      send_word(b2b_l[k], b2b_r[k], early);
      check("b2b_early", early, 32'h0);
      check("b2b_done", 32'(s2p_done), 32'h1);
      check("b2b_data_l", 32'(data_l), 32'(b2b_l[k]));
      check("b2b_data_r", 32'(data_r), 32'(b2b_r[k]));
    end

    // Frame with in_ready low: no capture
    in_ready = 1'b0;
    send_word(16'h1111, 16'h2222, early);
    step(1'b0, 1'b0, 1'b0);
    check("gate_early", early, 32'h0);
    check("gate_done", 32'(s2p_done), 32'h0);
    check("gate_data_l", 32'(data_l), 32'hFFFF);
    in_ready = 1'b1;
    step(1'b0, 1'b0, 1'b0);

    // Resync at bit 7: only the second word completes
    w = 16'hBEEF;
    d = 0;
    for (int i = 0; i < 7; i++) begin
      step(i == 0, w[15-i], 1'b1);
      if (s2p_done) d++;
    end
    send_word(16'h0F0F, 16'hF0F0, early);
    check("resync_early", d + early, 32'h0);
    check("resync_done", 32'(s2p_done), 32'h1);
    check("resync_data_l", 32'(data_l), 32'h0F0F);
    check("resync_data_r", 32'(data_r), 32'hF0F0);
    step(1'b0, 1'b0, 1'b0);

    // s2p_clear mid-word
    w = 16'h5555;
    for (int i = 0; i < 6; i++) step(i == 0, w[15-i], w[15-i]);
    s2p_clear = 1'b1;
    step(1'b0, w[9], w[9]);
    check("clr_data_l", 32'(data_l), 32'h0);
    check("clr_data_r", 32'(data_r), 32'h0);
    check("clr_done", 32'(s2p_done), 32'h0);
    check("clr_all_zeros", 32'(all_zeros), 32'h0);
    s2p_clear = 1'b0;
    d = 0;
    for (int i = 7; i < 16; i++) begin
      step(1'b0, w[15-i], w[15-i]);
      if (s2p_done) d++;
    end
    step(1'b0, 1'b0, 1'b0);
    if (s2p_done) d++;
    check("clr_no_done", d, 32'h0);
    check("clr_data_l_after", 32'(data_l), 32'h0);

    // reset_n mid-word
    send_word(16'h1357, 16'h2468, early);
    check("pre_rst_data_l", 32'(data_l), 32'h1357);
    w = 16'hC3A5;
    for (int i = 0; i < 6; i++) step(i == 0, w[15-i], w[15-i]);
    reset_n = 1'b0;
    step(1'b0, w[9], w[9]);
    check("rstmid_data_l", 32'(data_l), 32'h0);
    check("rstmid_data_r", 32'(data_r), 32'h0);
    check("rstmid_done", 32'(s2p_done), 32'h0);
    reset_n = 1'b1;
    d = 0;
    for (int i = 7; i < 16; i++) begin
      step(1'b0, w[15-i], w[15-i]);
      if (s2p_done) d++;
    end
    step(1'b0, 1'b0, 1'b0);
    if (s2p_done) d++;
    check("rstmid_no_done", d, 32'h0);

    // Sleep: 800th zero pair raises all_zeros with its s2p_done
    reset_n = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    zero_words(799, az_seen, dones);
    check("sleep_799_az_seen", az_seen, 32'h0);
    check("sleep_799_dones", dones, 32'd799);
    send_word(16'h0000, 16'h0000, early);
    check("sleep_800_done", 32'(s2p_done), 32'h1);
    check("sleep_800_az", 32'(all_zeros), 32'h1);

    // Wake: L=0x4000, all_zeros falls on the edge sampling bit 14
    step(1'b1, 1'b0, 1'b0);
    check("wake_msb_az", 32'(all_zeros), 32'h1);
    step(1'b0, 1'b1, 1'b0);
    check("wake_bit_az", 32'(all_zeros), 32'h0);
    for (int i = 2; i < 16; i++) step(1'b0, 1'b0, 1'b0);
    check("wake_done", 32'(s2p_done), 32'h1);
    check("wake_data_l", 32'(data_l), 32'h4000);
    check("wake_az_end", 32'(all_zeros), 32'h0);

    // Counter restarted: 799 more zeros stay awake, then R=0x0001 breaks the run
    zero_words(799, az_seen, dones);
    check("restart_799_az_seen", az_seen, 32'h0);
    send_word(16'h0000, 16'h0001, early);
    check("lsb_one_done", 32'(s2p_done), 32'h1);
    check("lsb_one_data_r", 32'(data_r), 32'h0001);
    check("lsb_one_az", 32'(all_zeros), 32'h0);
    zero_words(799, az_seen, dones);
    check("after_lsb_799_az_seen", az_seen, 32'h0);
    send_word(16'h0000, 16'h0000, early);
    check("after_lsb_800_az", 32'(all_zeros), 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
